// File: rtl/pmem_responder.sv
// Single-outstanding word-organised memory responder with a valid/ready request and response handshake.
// Every request spends LATENCY edges in BUSY, then holds its response in RESP until rsp_ready.
module pmem_responder #(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          we_q;
   logic [1:0]    size_q;
   logic [31:0]   addr_q, wdata_q;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   off, bit_mask, rd_data, wd_sh;
   logic [IW-1:0] idx;
   logic [4:0]    sh;
   logic [3:0]    lanes, wr_lanes;
   logic          illegal, commit;

   // Decode of the latched request; addresses below BASE wrap to a huge offset
   always_comb begin
      off = addr_q - BASE;
      idx = off[IW+1:2];
      sh  = {addr_q[1:0], 3'b000};
      case (size_q)
         2'd0:    lanes = 4'b0001;
         2'd1:    lanes = 4'b0011;
         default: lanes = 4'b1111;
      endcase
      bit_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      illegal  = (size_q == 2'd3) ||
                 (size_q == 2'd1 && addr_q[0]) ||
                 (size_q == 2'd2 && addr_q[1:0] != 2'd0) ||
                 (addr_q < BASE) ||
                 ((off >> 2) >= 32'(DEPTH));
      rd_data  = (mem[idx] >> sh) & bit_mask;
      wr_lanes = lanes << addr_q[1:0];
      wd_sh    = wdata_q << sh;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (req_valid) begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 1);
         end
         BUSY: if (cnt == 4'd0) state_nxt = RESP;
               else cnt_nxt = cnt - 4'd1;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign commit    = (state == BUSY) && (cnt == 4'd0);
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         we_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            rsp_rdata <= (illegal || we_q) ? 32'd0 : rd_data;
            rsp_err   <= illegal;
         end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Storage has no reset; a reset before commit simply never reaches this write
   always_ff @(posedge clk) begin
      if (commit && we_q && !illegal) begin
         for (int b = 0; b < 4; b++)
            if (wr_lanes[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
      end
   end
endmodule
